// File: rtl/cv32e40p_apu_core_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
//
// Purpose : Shared APU interface widths for cv32e40p cores and the defaults used
//           by the cluster-level FPU-sharing arbiter.
// Contents:
//   APU_NARGS_CPU      number of 32-bit operands per APU request
//   APU_WOP_CPU        opcode width
//   APU_NDSFLAGS_CPU   downstream (core -> FPU) flag width
//   APU_NUSFLAGS_CPU   upstream (FPU -> core) flag width
//   APU_ARB_NUM_CORES  default number of cores sharing one FPU
//   APU_ARB_FIFO_DEPTH default number of outstanding FPU operations
//   rr_wrap_inc()      round-robin successor of an index, wrapping at n
// -----------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

   localparam int APU_NARGS_CPU    = 3;
   localparam int APU_WOP_CPU      = 6;
   localparam int APU_NDSFLAGS_CPU = 15;
   localparam int APU_NUSFLAGS_CPU = 5;

   localparam int APU_ARB_NUM_CORES  = 2;
   localparam int APU_ARB_FIFO_DEPTH = 4;

   // Next index after idx in a ring of n entries. Written without a modulo
   // operator so it maps to a compare and an increment for any n.
   function automatic int unsigned rr_wrap_inc(input int unsigned idx,
                                                input int unsigned n);
      return ((idx + 1) >= n) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_tag_fifo
//
// Purpose : Small in-order FIFO holding the index of the core that issued each
//           outstanding FPU operation. The head is read combinationally so a
//           response can be steered in the cycle it arrives.
// Ports   :
//   clk        clock
//   rst_n      synchronous active-low reset (pointers and count cleared)
//   push       write push_data at the tail (ignored when full)
//   push_data  tag to store
//   pop        drop the head entry (ignored when empty)
//   full       count == DEPTH (registered count, not relieved by a same-cycle pop)
//   empty      count == 0
//   head       oldest stored tag
// -----------------------------------------------------------------------------
module cv32e40p_apu_tag_fifo
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int DEPTH = APU_ARB_FIFO_DEPTH,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic do_push;
   logic do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while count_q says valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_arbiter
//
// Purpose : Shares one FPU (APU slave) between NUM_CORES cv32e40p cores.
//           Requests are arbitrated round-robin, combinationally; results come
//           back from the FPU in issue order and are steered to the issuing
//           core via an in-order tag FIFO.
// Ports   :
//   clk_i, rst_ni          clock, synchronous active-low reset
//   core_req_i/gnt_o       per-core request / grant
//   core_operands_i/op_i/flags_i   per-core request payload
//   core_rvalid_o          per-core result valid (one-hot or zero)
//   core_result_o/rflags_o result and flags, broadcast to all cores
//   fpu_req_o/gnt_i        FPU request handshake
//   fpu_operands_o/op_o/flags_o    winner's payload, zero when not requesting
//   fpu_rvalid_i/result_i/rflags_i FPU response
//   err_o                  sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module cv32e40p_apu_arbiter
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int NUM_CORES  = APU_ARB_NUM_CORES,
   parameter int FIFO_DEPTH = APU_ARB_FIFO_DEPTH
) (
   input  logic                                              clk_i,
   input  logic                                              rst_ni,

   input  logic [NUM_CORES-1:0]                              core_req_i,
   output logic [NUM_CORES-1:0]                              core_gnt_o,
   input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]     core_operands_i,
   input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]             core_op_i,
   input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]        core_flags_i,
   output logic [NUM_CORES-1:0]                              core_rvalid_o,
   output logic [31:0]                                       core_result_o,
   output logic [APU_NUSFLAGS_CPU-1:0]                       core_rflags_o,

   output logic                                              fpu_req_o,
   input  logic                                              fpu_gnt_i,
   output logic [APU_NARGS_CPU-1:0][31:0]                    fpu_operands_o,
   output logic [APU_WOP_CPU-1:0]                            fpu_op_o,
   output logic [APU_NDSFLAGS_CPU-1:0]                       fpu_flags_o,
   input  logic                                              fpu_rvalid_i,
   input  logic [31:0]                                       fpu_result_i,
   input  logic [APU_NUSFLAGS_CPU-1:0]                       fpu_rflags_i,

   output logic                                              err_o
);

   localparam int IDX_W = $clog2(NUM_CORES);

   logic [IDX_W-1:0]                 rr_q;
   logic                             err_q;

   // Core index visited at each search offset, starting from rr_q.
   logic [NUM_CORES-1:0][IDX_W-1:0]  cand_idx;
   logic [NUM_CORES-1:0]             cand_req;

   logic [IDX_W-1:0]                 winner;
   logic                             any_req;
   logic                             issue;

   logic                             fifo_full;
   logic                             fifo_empty;
   logic [IDX_W-1:0]                 fifo_head;
   logic                             resp_ok;

   // ---------------------------------------------------------------------------
   // Round-robin search: offset gi looks at core (rr_q + gi) wrapped into range.
   // The sum fits in IDX_W+1 bits because both terms are below NUM_CORES.
   // ---------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum           = {1'b0, rr_q} + (IDX_W+1)'(gi);
      assign cand_idx[gi]  = (sum >= (IDX_W+1)'(NUM_CORES))
                             ? IDX_W'(sum - (IDX_W+1)'(NUM_CORES))
                             : IDX_W'(sum);
      assign cand_req[gi]  = core_req_i[cand_idx[gi]];
   end

   // Walk offsets from the far end so the smallest requesting offset wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (cand_req[i]) begin
            winner = cand_idx[i];
         end
      end
   end

   assign any_req   = |core_req_i;
   assign fpu_req_o = any_req & ~fifo_full;
   assign issue     = fpu_req_o & fpu_gnt_i;

   // ---------------------------------------------------------------------------
   // Payload multiplexer, forced to zero while no request is presented.
   // ---------------------------------------------------------------------------
   always_comb begin
      fpu_operands_o = '0;
      fpu_op_o       = '0;
      fpu_flags_o    = '0;
      if (fpu_req_o) begin
         fpu_operands_o = core_operands_i[winner];
         fpu_op_o       = core_op_i[winner];
         fpu_flags_o    = core_flags_i[winner];
      end
   end

   // ---------------------------------------------------------------------------
   // Grant and response steering. A response with no outstanding tag is
   // dropped rather than delivered to whatever stale entry sits at the head.
   // ---------------------------------------------------------------------------
   assign resp_ok = fpu_rvalid_i & ~fifo_empty;

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign core_gnt_o[gi]    = issue   & (winner    == IDX_W'(gi));
      assign core_rvalid_o[gi] = resp_ok & (fifo_head == IDX_W'(gi));
   end

   assign core_result_o = fpu_result_i;
   assign core_rflags_o = fpu_rflags_i;

   // ---------------------------------------------------------------------------
   // Tag FIFO: one entry per operation in flight inside the FPU.
   // ---------------------------------------------------------------------------
   cv32e40p_apu_tag_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IDX_W)
   ) u_tag_fifo (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .push      (issue),
      .push_data (winner),
      .pop       (resp_ok),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // ---------------------------------------------------------------------------
   // Pointer and sticky error state.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (issue) begin
            rr_q <= IDX_W'(rr_wrap_inc(32'(winner), NUM_CORES));
         end
         if (fpu_rvalid_i & fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_apu_arbiter
//
// Purpose : Self-checking bench for cv32e40p_apu_arbiter (2 cores, depth 4).
//           A queue-based reference model predicts every output each cycle;
//           directed scenarios add fixed expectations, then a random phase runs.
// -----------------------------------------------------------------------------
module tb_cv32e40p_apu_arbiter;
   import cv32e40p_apu_core_pkg::*;

   localparam int NC = 2;
   localparam int FD = 4;

   logic                                          clk = 1'b0;
   logic                                          rst_n;
   logic [NC-1:0]                                 core_req;
   logic [NC-1:0]                                 core_gnt;
   logic [NC-1:0][APU_NARGS_CPU-1:0][31:0]        core_operands;
   logic [NC-1:0][APU_WOP_CPU-1:0]                core_op;
   logic [NC-1:0][APU_NDSFLAGS_CPU-1:0]           core_flags;
   logic [NC-1:0]                                 core_rvalid;
   logic [31:0]                                   core_result;
   logic [APU_NUSFLAGS_CPU-1:0]                   core_rflags;
   logic                                          fpu_req;
   logic                                          fpu_gnt;
   logic [APU_NARGS_CPU-1:0][31:0]                fpu_operands;
   logic [APU_WOP_CPU-1:0]                        fpu_op;
   logic [APU_NDSFLAGS_CPU-1:0]                   fpu_flags;
   logic                                          fpu_rvalid;
   logic [31:0]                                   fpu_result;
   logic [APU_NUSFLAGS_CPU-1:0]                   fpu_rflags;
   logic                                          err;

   cv32e40p_apu_arbiter #(
      .NUM_CORES  (NC),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .core_req_i      (core_req),
      .core_gnt_o      (core_gnt),
      .core_operands_i (core_operands),
      .core_op_i       (core_op),
      .core_flags_i    (core_flags),
      .core_rvalid_o   (core_rvalid),
      .core_result_o   (core_result),
      .core_rflags_o   (core_rflags),
      .fpu_req_o       (fpu_req),
      .fpu_gnt_i       (fpu_gnt),
      .fpu_operands_o  (fpu_operands),
      .fpu_op_o        (fpu_op),
      .fpu_flags_o     (fpu_flags),
      .fpu_rvalid_i    (fpu_rvalid),
      .fpu_result_i    (fpu_result),
      .fpu_rflags_i    (fpu_rflags),
      .err_o           (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: outstanding issuers in order, pointer, sticky error.
   int            tagq[$];
   int            m_rr  = 0;
   bit            m_err = 1'b0;
   logic [NC-1:0] m_gnt_last = '0;

   // Values observed at the most recent sampling point.
   logic [NC-1:0] obs_gnt;
   logic [NC-1:0] obs_rvalid;
   logic          obs_fpu_req;
   logic          obs_err;
   logic [31:0]   obs_result;
   logic [APU_WOP_CPU-1:0] obs_op;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, compare against the model,
   // advance the model, then return just after the next rising edge.
   task automatic step();
      int                              w;
      int                              c;
      bit                              m_full;
      bit                              m_req;
      logic [NC-1:0]                   e_gnt;
      logic [NC-1:0]                   e_rv;
      logic [APU_NARGS_CPU-1:0][31:0]  e_ops;
      logic [APU_WOP_CPU-1:0]          e_op;
      logic [APU_NDSFLAGS_CPU-1:0]     e_fl;

      @(negedge clk);
      w = -1;
      for (int k = 0; k < NC; k++) begin
         c = (m_rr + k) % NC;
         if (w < 0 && core_req[c]) w = c;
      end
      m_full = (tagq.size() == FD);
      m_req  = (w >= 0) && !m_full;
      e_gnt  = '0;
      e_ops  = '0;
      e_op   = '0;
      e_fl   = '0;
      if (m_req) begin
         e_ops = core_operands[w];
         e_op  = core_op[w];
         e_fl  = core_flags[w];
         if (fpu_gnt) e_gnt[w] = 1'b1;
      end
      e_rv = '0;
      if (fpu_rvalid && tagq.size() > 0) e_rv[tagq[0]] = 1'b1;

      obs_gnt     = core_gnt;
      obs_rvalid  = core_rvalid;
      obs_fpu_req = fpu_req;
      obs_err     = err;
      obs_result  = core_result;
      obs_op      = fpu_op;

      chk("fpu_req",  128'(fpu_req),      128'(m_req));
      chk("gnt",      128'(core_gnt),     128'(e_gnt));
      chk("operands", 128'(fpu_operands), 128'(e_ops));
      chk("op",       128'(fpu_op),       128'(e_op));
      chk("flags",    128'(fpu_flags),    128'(e_fl));
      chk("rvalid",   128'(core_rvalid),  128'(e_rv));
      chk("result",   128'(core_result),  128'(fpu_result));
      chk("rflags",   128'(core_rflags),  128'(fpu_rflags));
      chk("err",      128'(err),          128'(m_err));

      m_gnt_last = e_gnt;
      if (!rst_n) begin
         tagq.delete();
         m_rr  = 0;
         m_err = 1'b0;
      end else begin
         if (fpu_rvalid) begin
            if (tagq.size() > 0) void'(tagq.pop_front());
            else m_err = 1'b1;
         end
         if (m_req && fpu_gnt) begin
            tagq.push_back(w);
            m_rr = (w + 1) % NC;
         end
      end

      $display("t=%0t rst_n=%0b req=%b gnt=%b fpu_req=%0b rvalid=%b err=%0b outstanding=%0d",
               $time, rst_n, core_req, obs_gnt, obs_fpu_req, obs_rvalid, obs_err, tagq.size());
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [NC-1:0] req, input logic g, input logic rv,
                         input logic [31:0] res);
      core_req   = req;
      fpu_gnt    = g;
      fpu_rvalid = rv;
      fpu_result = res;
      fpu_rflags = APU_NUSFLAGS_CPU'($urandom);
      for (int c = 0; c < NC; c++) begin
         core_op[c]    = APU_WOP_CPU'($urandom);
         core_flags[c] = APU_NDSFLAGS_CPU'($urandom);
         for (int a = 0; a < APU_NARGS_CPU; a++) core_operands[c][a] = $urandom;
      end
   endtask

   logic [NC-1:0] fair_seq [4];
   logic [NC-1:0] drain_seq [4];

   initial begin
      fair_seq  = '{2'b01, 2'b10, 2'b01, 2'b10};
      drain_seq = '{2'b10, 2'b01, 2'b10, 2'b01};

      rst_n = 1'b0;
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      step();
      step();
      chk("rst_gnt",     128'(obs_gnt),     128'(2'b00));
      chk("rst_rvalid",  128'(obs_rvalid),  128'(2'b00));
      chk("rst_fpu_req", 128'(obs_fpu_req), 128'(1'b0));
      chk("rst_err",     128'(obs_err),     128'(1'b0));
      rst_n = 1'b1;

      // Single requester: core1 issues op 3, result three cycles later.
      set_in(2'b10, 1'b1, 1'b0, 32'h0);
      core_op[1] = 6'h3;
      step();
      chk("single_gnt", 128'(obs_gnt), 128'(2'b10));
      chk("single_op",  128'(obs_op),  128'(6'h3));
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      step();
      step();
      set_in(2'b00, 1'b0, 1'b1, 32'h3F80_0000);
      step();
      chk("single_rvalid", 128'(obs_rvalid), 128'(2'b10));
      chk("single_result", 128'(obs_result), 128'(32'h3F80_0000));

      // Fairness: both request continuously; pointer returned to core0.
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, 1'b1, 1'b0, 32'h0);
         step();
         chk("fair_gnt", 128'(obs_gnt), 128'(fair_seq[i]));
      end

      // FIFO full: four outstanding, no request may go out.
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      step();
      chk("full_req", 128'(obs_fpu_req), 128'(1'b0));
      chk("full_gnt", 128'(obs_gnt),     128'(2'b00));
      set_in(2'b11, 1'b1, 1'b1, 32'h1234_5678);
      step();
      chk("full_pop_rvalid", 128'(obs_rvalid),  128'(2'b01));
      chk("full_pop_req",    128'(obs_fpu_req), 128'(1'b0));
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      step();
      chk("full_relief_req", 128'(obs_fpu_req), 128'(1'b1));
      chk("full_relief_gnt", 128'(obs_gnt),     128'(2'b01));

      // Responses come back in issue order.
      for (int i = 0; i < 4; i++) begin
         set_in(2'b00, 1'b0, 1'b1, $urandom);
         step();
         chk("drain_rvalid", 128'(obs_rvalid), 128'(drain_seq[i]));
      end

      // Simultaneous push and pop at two outstanding keeps the count at two.
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      step();
      step();
      set_in(2'b11, 1'b1, 1'b1, 32'hCAFE_0001);
      step();
      chk("pp_gnt",    128'(obs_gnt),    128'(2'b10));
      chk("pp_rvalid", 128'(obs_rvalid), 128'(2'b10));
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      step();
      chk("pp_room1", 128'(obs_fpu_req), 128'(1'b1));
      step();
      chk("pp_room2", 128'(obs_fpu_req), 128'(1'b1));
      step();
      chk("pp_full", 128'(obs_fpu_req), 128'(1'b0));
      for (int i = 0; i < 4; i++) begin
         set_in(2'b00, 1'b0, 1'b1, $urandom);
         step();
      end

      // Spurious response with nothing outstanding.
      set_in(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
      step();
      chk("spur_rvalid", 128'(obs_rvalid), 128'(2'b00));
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      step();
      chk("spur_err", 128'(obs_err), 128'(1'b1));
      step();
      chk("spur_err_hold", 128'(obs_err), 128'(1'b1));

      // Reset with three operations in flight.
      for (int i = 0; i < 3; i++) begin
         set_in(2'b11, 1'b1, 1'b0, 32'h0);
         step();
      end
      rst_n = 1'b0;
      set_in(2'b00, 1'b0, 1'b0, 32'h0);
      step();
      rst_n = 1'b1;
      set_in(2'b11, 1'b1, 1'b0, 32'h0);
      step();
      chk("mid_rst_gnt", 128'(obs_gnt), 128'(2'b01));
      chk("mid_rst_err", 128'(obs_err), 128'(1'b0));
      step();
      step();
      step();
      chk("mid_rst_last_room", 128'(obs_fpu_req), 128'(1'b1));
      step();
      chk("mid_rst_full", 128'(obs_fpu_req), 128'(1'b0));
      for (int i = 0; i < 4; i++) begin
         set_in(2'b00, 1'b0, 1'b1, $urandom);
         step();
      end

      // Random traffic; cores hold requests until granted.
      for (int n = 0; n < 2000; n++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         for (int c = 0; c < NC; c++) begin
            if (!(core_req[c] && !m_gnt_last[c])) begin
               core_req[c]   = 1'($urandom_range(0, 1));
               core_op[c]    = APU_WOP_CPU'($urandom);
               core_flags[c] = APU_NDSFLAGS_CPU'($urandom);
               for (int a = 0; a < APU_NARGS_CPU; a++) core_operands[c][a] = $urandom;
            end
         end
         fpu_gnt    = ($urandom_range(0, 3) != 0);
         fpu_rvalid = (tagq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 49) == 0);
         fpu_result = $urandom;
         fpu_rflags = APU_NUSFLAGS_CPU'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
# cv32e40p_apu_arbiter

Round-robin arbiter that shares one FPU instance (APU slave side) between `NUM_CORES` cv32e40p cores in a cluster. It sits between the cores' APU master ports and a single `cv32e40p_fp_wrapper`. Request arbitration is combinational and fair. Responses come back from the FPU in issue order and are steered to the issuing core through an in-order tag FIFO.

## Interface

Parameters:
- `NUM_CORES`, 2: number of requesting cores; range 2..8.
- `FIFO_DEPTH`, 4: maximum outstanding FPU operations; power of two, at least 2.
- Widths `APU_NARGS_CPU`, `APU_WOP_CPU`, `APU_NDSFLAGS_CPU` and `APU_NUSFLAGS_CPU` come from `cv32e40p_apu_core_pkg`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `core_req_i`  in  [NUM_CORES]  per-core APU request.
- `core_gnt_o`  out  [NUM_CORES]  per-core grant.
- `core_operands_i`  in  [NUM_CORES][APU_NARGS_CPU][32]  operands.
- `core_op_i`  in  [NUM_CORES][APU_WOP_CPU]  opcode.
- `core_flags_i`  in  [NUM_CORES][APU_NDSFLAGS_CPU]  downstream flags.
- `core_rvalid_o`  out  [NUM_CORES]  result valid, one-hot or zero.
- `core_result_o`  out  32  result, broadcast to all cores.
- `core_rflags_o`  out  APU_NUSFLAGS_CPU  result flags, broadcast to all cores.
- `fpu_req_o`, `fpu_gnt_i`, `fpu_operands_o`, `fpu_op_o`, `fpu_flags_o`  FPU request side, same widths as a single core port.
- `fpu_rvalid_i`  in  1  FPU result valid.
- `fpu_result_i`  in  32  FPU result.
- `fpu_rflags_i`  in  APU_NUSFLAGS_CPU  FPU result flags.
- `err_o`  out  1  sticky protocol error.

## Operation

- **Round-robin pointer** `rr_q` (index width `IDX_W = $clog2(NUM_CORES)`).
  - The winner is the first requesting core at or after `rr_q`, searching upward with wrap-around.
- **Issue conditions**
  - `fpu_req_o` = (any `core_req_i`) AND NOT `full`.
  - `full` means `count_q == FIFO_DEPTH`. A pop in the same cycle does not relieve `full`.
  - `fpu_operands_o`, `fpu_op_o` and `fpu_flags_o` carry the winner's fields. They are zero when `fpu_req_o` = 0.
  - `core_gnt_o[winner]` = `fpu_req_o` AND `fpu_gnt_i`. All other grant bits are 0.
- **Accepted issue** (`fpu_req_o` AND `fpu_gnt_i`):
  - Push the winner index into the tag FIFO.
  - `rr_q` <= (winner + 1) mod `NUM_CORES`.
  - With no accepted issue, `rr_q` holds.
- **Response routing** (`fpu_rvalid_i`):
  - With the FIFO non-empty: pop the head, and set `core_rvalid_o[head]` = 1 in the same cycle.
  - `core_result_o` and `core_rflags_o` pass `fpu_result_i` and `fpu_rflags_i` straight through.
  - With the FIFO empty: drop the response, keep `core_rvalid_o` = 0, and set `err_o` = 1. `err_o` stays set until reset.
- **Simultaneous push and pop:** legal when not full; `count_q` is unchanged.
- **Reset** (`rst_ni` = 0 at a clock edge), including mid-operation:
  - `rr_q` = 0, `count_q` = 0, FIFO pointers = 0, `err_o` = 0.
  - In-flight tags are discarded.
  - The FPU is reset by the same `rst_ni`, so no stale responses follow.
- **Core-side contract:** a core keeps `core_req_i` and its fields stable until granted. The arbiter does not check this.

## Timing

- Arbitration and the grant path are combinational from `core_req_i`, `rr_q`, `count_q` and `fpu_gnt_i`, with no added latency.
- The response path is combinational from `fpu_rvalid_i` and the FIFO head. Added latency is 0 cycles.
- `count_q`, FIFO pointers, `rr_q` and `err_o` update at the rising edge of `clk_i`.
- Reset values of combinational outputs:
  - `core_gnt_o` = 0 and `core_rvalid_o` = 0 while inputs are idle.
  - `fpu_req_o` = 0 when no core requests.
- At most one issue and one response per cycle.

## Structure

- `cv32e40p_apu_core_pkg` already holds the APU width constants. Add the `APU_ARB_NUM_CORES` and `APU_ARB_FIFO_DEPTH` defaults to it.
- Sub-module `cv32e40p_apu_tag_fifo`:
  - Parameters: `DEPTH`, `WIDTH`.
  - Synchronous FIFO with `push`, `pop`, `full`, `empty` and `head`.
  - Count register of width `$clog2(DEPTH)+1`, with wrap-around read and write pointers.
- The top level holds the round-robin search loop, the operand multiplexer, the error flag and the FIFO instance.

## Test plan

- **Single requester.** `NUM_CORES`=2. Core1 issues op 0x3 with `fpu_gnt_i`=1 and the FPU returns result 0x3F800000 three cycles later. Required: `core_gnt_o`=2'b10 in the issue cycle, `rr_q`=0 afterwards, `core_rvalid_o`=2'b10 with result 0x3F800000.
- **Fairness.** Both cores request continuously and `fpu_gnt_i`=1 every cycle. Required grant sequence: 01, 10, 01, 10. Responses return in order and `core_rvalid_o` alternates in the same way.
- **FIFO full.** `FIFO_DEPTH`=4, 4 ops issued and no `fpu_rvalid_i`. Required: `fpu_req_o`=0 and no grants. Pulsing `fpu_rvalid_i` once pops a tag, and `fpu_req_o` returns to 1 on the next cycle.
- **Simultaneous push and pop.** `count_q`=2, then an issue and a response in the same cycle. Required: `count_q` stays 2, and the head core receives rvalid.
- **Spurious response.** `fpu_rvalid_i`=1 with the FIFO empty. Required: `core_rvalid_o`=0 and `err_o`=1, held until `rst_ni`=0.
- **Reset mid-operation.** 3 ops outstanding, then `rst_ni`=0 for one cycle. Required: `count_q`=0, `rr_q`=0, `err_o`=0, and the next grant goes to core0 when both cores request.
